// File: rtl/cdi_slave_pkg.sv
// rtl/cdi_slave_pkg.sv - shared types and constants for the slave bus bridge
package cdi_slave_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DELAY,
      IRQ,
      WAIT_DTACK,
      ACK,
      RELEASE
   } slave_state_t;

   localparam logic [7:0] SLAVE_FIX_IN       = 8'h01;
   localparam logic [7:0] SLAVE_FIX_OUT      = 8'h02;
   localparam logic [7:0] SLAVE_TIMEOUT_DATA = 8'hFF;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/slave_bus_bridge_dtack_edge_det.sv
// rtl/slave_bus_bridge_dtack_edge_det.sv - rising-edge detector for the slave dtack line
module dtack_edge_det (
   input  logic clk,
   input  logic resetn,
   input  logic in_n,
   output logic rise
);

   logic in_n_q;
   logic in_n_d;

   always_comb begin
      in_n_d = in_n;
   end

   // Reset high so a line already high after reset is not seen as an edge
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         in_n_q <= 1'b1;
      end else begin
         in_n_q <= in_n_d;
      end
   end

   assign rise = in_n && !in_n_q;

endmodule

// File: rtl/slave_bus_bridge.sv
// rtl/slave_bus_bridge.sv - bridges CPU accesses in the slave window to the slave controller ports
module slave_bus_bridge
   import cdi_slave_pkg::*;
#(
   parameter int IRQ_DELAY = 20,
   parameter int IRQ_WIDTH = 4,
   parameter int TIMEOUT   = 4096
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cs,
   input  logic [1:0]  cpu_address,
   input  logic [15:0] cpu_din,
   input  logic        cpu_uds,
   input  logic        cpu_lds,
   input  logic        cpu_write_strobe,
   output logic [15:0] cpu_dout,
   output logic        cpu_bus_ack,
   output logic        cpu_int2,
   output logic        timeout,
   output logic [7:0]  slave_data_to,
   input  logic [7:0]  slave_data_from,
   output logic [1:0]  slave_addr,
   output logic        slave_rw_n,
   input  logic        slave_dtackn,
   input  logic        slave_in2n,
   output logic        slave_irqn
);

   localparam int CNT_W = $clog2(max3(IRQ_DELAY, IRQ_WIDTH, TIMEOUT)) + 1;

   slave_state_t       state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        cpu_dout_q, cpu_dout_d;
   logic               cpu_bus_ack_q, cpu_bus_ack_d;
   logic               cpu_int2_q, cpu_int2_d;
   logic               timeout_q, timeout_d;
   logic [7:0]         slave_data_to_q, slave_data_to_d;
   logic [1:0]         slave_addr_q, slave_addr_d;
   logic               slave_rw_n_q, slave_rw_n_d;
   logic               slave_irqn_q, slave_irqn_d;
   logic               dtack_rise;
   logic [7:0]         rd;

   dtack_edge_det u_dtack_edge_det (
      .clk    (clk),
      .resetn (resetn),
      .in_n   (slave_dtackn),
      .rise   (dtack_rise)
   );

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      cpu_dout_d      = cpu_dout_q;
      cpu_bus_ack_d   = 1'b0;
      timeout_d       = 1'b0;
      cpu_int2_d      = !slave_in2n;
      slave_data_to_d = slave_data_to_q;
      slave_addr_d    = slave_addr_q;
      slave_rw_n_d    = slave_rw_n_q;
      slave_irqn_d    = 1'b1;
      // The slave firmware cannot return 0x01; it reports it as 0x02
      rd = (slave_data_from == SLAVE_FIX_IN) ? SLAVE_FIX_OUT : slave_data_from;

      case (state_q)
         IDLE: begin
            if (cs && (cpu_uds || cpu_lds)) begin
               slave_addr_d    = cpu_address;
               slave_rw_n_d    = !cpu_write_strobe;
               slave_data_to_d = cpu_uds ? cpu_din[15:8] : cpu_din[7:0];
               cnt_d           = '0;
               state_d         = DELAY;
            end
         end
         DELAY: begin
            if (!cs) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == CNT_W'(IRQ_DELAY - 1)) begin
               cnt_d        = '0;
               slave_irqn_d = 1'b0;
               state_d      = IRQ;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         IRQ: begin
            if (!cs) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == CNT_W'(IRQ_WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = WAIT_DTACK;
            end else begin
               cnt_d        = cnt_q + CNT_W'(1);
               slave_irqn_d = 1'b0;
            end
         end
         WAIT_DTACK: begin
            if (!cs) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (dtack_rise) begin
               cnt_d         = '0;
               cpu_dout_d    = {rd, rd};
               cpu_bus_ack_d = 1'b1;
               state_d       = ACK;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               cnt_d         = '0;
               cpu_dout_d    = {SLAVE_TIMEOUT_DATA, SLAVE_TIMEOUT_DATA};
               cpu_bus_ack_d = 1'b1;
               timeout_d     = 1'b1;
               state_d       = ACK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ACK: begin
            state_d = RELEASE;
         end
         RELEASE: begin
            if (!cs || !(cpu_uds || cpu_lds)) begin
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         cpu_dout_q      <= 16'h0000;
         cpu_bus_ack_q   <= 1'b0;
         cpu_int2_q      <= 1'b0;
         timeout_q       <= 1'b0;
         slave_data_to_q <= 8'h00;
         slave_addr_q    <= 2'b00;
         slave_rw_n_q    <= 1'b1;
         slave_irqn_q    <= 1'b1;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         cpu_dout_q      <= cpu_dout_d;
         cpu_bus_ack_q   <= cpu_bus_ack_d;
         cpu_int2_q      <= cpu_int2_d;
         timeout_q       <= timeout_d;
         slave_data_to_q <= slave_data_to_d;
         slave_addr_q    <= slave_addr_d;
         slave_rw_n_q    <= slave_rw_n_d;
         slave_irqn_q    <= slave_irqn_d;
      end
   end

   assign cpu_dout      = cpu_dout_q;
   assign cpu_bus_ack   = cpu_bus_ack_q;
   assign cpu_int2      = cpu_int2_q;
   assign timeout       = timeout_q;
   assign slave_data_to = slave_data_to_q;
   assign slave_addr    = slave_addr_q;
   assign slave_rw_n    = slave_rw_n_q;
   assign slave_irqn    = slave_irqn_q;

endmodule

// File: tb/tb_slave_bus_bridge.sv
// tb/tb_slave_bus_bridge.sv - self-checking bench for slave_bus_bridge
module tb_slave_bus_bridge;

   localparam int D  = 20;
   localparam int W  = 4;
   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cs = 1'b0;
   logic [1:0]  cpu_address = 2'b00;
   logic [15:0] cpu_din = 16'h0000;
   logic        cpu_uds = 1'b0;
   logic        cpu_lds = 1'b0;
   logic        cpu_write_strobe = 1'b0;
   logic [15:0] cpu_dout;
   logic        cpu_bus_ack;
   logic        cpu_int2;
   logic        timeout;
   logic [7:0]  slave_data_to;
   logic [7:0]  slave_data_from = 8'h00;
   logic [1:0]  slave_addr;
   logic        slave_rw_n;
   logic        slave_dtackn = 1'b1;
   logic        slave_in2n = 1'b1;
   logic        slave_irqn;

   slave_bus_bridge #(.IRQ_DELAY(D), .IRQ_WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .resetn(resetn), .cs(cs), .cpu_address(cpu_address),
      .cpu_din(cpu_din), .cpu_uds(cpu_uds), .cpu_lds(cpu_lds),
      .cpu_write_strobe(cpu_write_strobe), .cpu_dout(cpu_dout),
      .cpu_bus_ack(cpu_bus_ack), .cpu_int2(cpu_int2), .timeout(timeout),
      .slave_data_to(slave_data_to), .slave_data_from(slave_data_from),
      .slave_addr(slave_addr), .slave_rw_n(slave_rw_n),
      .slave_dtackn(slave_dtackn), .slave_in2n(slave_in2n), .slave_irqn(slave_irqn)
   );

   always #5 clk = ~clk;

   // Reference model: an access is a timeline measured from its start edge
   logic        m_busy, m_hold, m_prev;
   int          m_t;
   logic [15:0] exp_dout;
   logic        exp_ack, exp_to, exp_int2, exp_rw, exp_irqn;
   logic [7:0]  exp_data_to;
   logic [1:0]  exp_addr;
   wire         m_rise = slave_dtackn && !m_prev;
   wire  [7:0]  m_fix  = (slave_data_from == 8'h01) ? 8'h02 : slave_data_from;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_busy <= 1'b0; m_hold <= 1'b0; m_prev <= 1'b1; m_t <= 0;
         exp_dout <= 16'h0000; exp_ack <= 1'b0; exp_to <= 1'b0; exp_int2 <= 1'b0;
         exp_data_to <= 8'h00; exp_addr <= 2'b00; exp_rw <= 1'b1; exp_irqn <= 1'b1;
      end else begin
         m_prev   <= slave_dtackn;
         exp_int2 <= !slave_in2n;
         exp_ack  <= 1'b0;
         exp_to   <= 1'b0;
         if (m_hold) begin
            if (!cs || !(cpu_uds || cpu_lds)) m_hold <= 1'b0;
         end else if (m_busy) begin
            if (!cs) begin
               m_busy   <= 1'b0;
               exp_irqn <= 1'b1;
            end else if (m_t >= D + W && (m_rise || m_t == D + W + TO - 1)) begin
               m_busy   <= 1'b0;
               m_hold   <= 1'b1;
               exp_ack  <= 1'b1;
               exp_to   <= !m_rise;
               exp_dout <= m_rise ? {m_fix, m_fix} : 16'hFFFF;
               exp_irqn <= 1'b1;
            end else begin
               m_t      <= m_t + 1;
               exp_irqn <= !((m_t + 1) >= D && (m_t + 1) < D + W);
            end
         end else if (cs && (cpu_uds || cpu_lds)) begin
            m_busy      <= 1'b1;
            m_t         <= 0;
            exp_addr    <= cpu_address;
            exp_rw      <= !cpu_write_strobe;
            exp_data_to <= cpu_uds ? cpu_din[15:8] : cpu_din[7:0];
            exp_irqn    <= 1'b1;
         end
      end
   end

   int tests_run = 0;
   int tests_failed = 0;
   int ncyc = 0;
   int start_cyc = 0;
   int irq_low = 0, irq_first = -1, acks = 0, ack_rel = -1, tos = 0;
   logic [15:0] ack_dout = 16'h0000;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      ncyc++;
      chk("dout", cpu_dout, exp_dout);
      chk("bus_ack", 16'(cpu_bus_ack), 16'(exp_ack));
      chk("timeout", 16'(timeout), 16'(exp_to));
      chk("int2", 16'(cpu_int2), 16'(exp_int2));
      chk("data_to", 16'(slave_data_to), 16'(exp_data_to));
      chk("addr", 16'(slave_addr), 16'(exp_addr));
      chk("rw_n", 16'(slave_rw_n), 16'(exp_rw));
      chk("irqn", 16'(slave_irqn), 16'(exp_irqn));
      if (!slave_irqn) begin
         irq_low++;
         if (irq_first < 0) irq_first = ncyc - start_cyc - 1;
      end
      if (cpu_bus_ack) begin
         acks++;
         ack_dout = cpu_dout;
         ack_rel  = ncyc - start_cyc - 1;
      end
      if (timeout) tos++;
   endtask

   task automatic start_access(input logic [1:0] a, input logic [15:0] din,
                               input logic u, input logic l, input logic we);
      cpu_address = a; cpu_din = din; cpu_uds = u; cpu_lds = l; cpu_write_strobe = we;
      cs = 1'b1;
      slave_dtackn = 1'b0;
      start_cyc = ncyc;
      irq_low = 0; irq_first = -1; acks = 0; ack_rel = -1; tos = 0;
   endtask

   task automatic wait_irq();
      int n = 0;
      while (slave_irqn && n < 100) begin tick(); n++; end
      chk("irq_seen", 16'(!slave_irqn), 16'd1);
   endtask

   task automatic wait_ack(input int budget);
      int n = 0;
      while (acks == 0 && n < budget) begin tick(); n++; end
      chk("ack_seen", 16'(acks > 0), 16'd1);
   endtask

   task automatic release_bus();
      cs = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0; cpu_write_strobe = 1'b0;
      tick(); tick();
   endtask

   task automatic read_access(input logic [1:0] a, input logic [7:0] sd,
                              input logic [15:0] exp_d, input bit glitch);
      start_access(a, 16'h0000, 1'b1, 1'b1, 1'b0);
      if (glitch) begin
         repeat (5) tick();
         slave_dtackn = 1'b1;
         tick();
         slave_dtackn = 1'b0;
      end
      wait_irq();
      repeat (7) tick();
      slave_data_from = sd;
      slave_dtackn = 1'b1;
      wait_ack(50);
      repeat (5) tick();
      chk("rd_addr", 16'(slave_addr), 16'(a));
      chk("rd_rw_n", 16'(slave_rw_n), 16'd1);
      chk("rd_irq_first", 16'(irq_first), 16'd20);
      chk("rd_irq_len", 16'(irq_low), 16'd4);
      chk("rd_ack_count", 16'(acks), 16'd1);
      chk("rd_ack_latency", 16'(ack_rel), 16'd28);
      chk("rd_dout", ack_dout, exp_d);
      release_bus();
   endtask

   initial begin
      tick(); tick();
      chk("rst_irqn", 16'(slave_irqn), 16'd1);
      chk("rst_rw_n", 16'(slave_rw_n), 16'd1);
      chk("rst_dout", cpu_dout, 16'h0000);
      resetn = 1'b1;
      tick(); tick();

      read_access(2'b10, 8'h5A, 16'h5A5A, 1'b0);

      start_access(2'b00, 16'hC312, 1'b1, 1'b0, 1'b1);
      tick();
      chk("wr_data_to", 16'(slave_data_to), 16'h00C3);
      chk("wr_rw_n", 16'(slave_rw_n), 16'd0);
      wait_irq();
      repeat (20) tick();
      chk("wr_no_early_ack", 16'(acks), 16'd0);
      slave_data_from = 8'h77;
      slave_dtackn = 1'b1;
      wait_ack(20);
      chk("wr_ack_count", 16'(acks), 16'd1);
      chk("wr_dout", ack_dout, 16'h7777);
      release_bus();

      read_access(2'b01, 8'h01, 16'h0202, 1'b1);

      start_access(2'b11, 16'h0000, 1'b0, 1'b1, 1'b0);
      wait_ack(200);
      tick(); tick();
      chk("to_pulses", 16'(tos), 16'd1);
      chk("to_ack_count", 16'(acks), 16'd1);
      chk("to_ack_latency", 16'(ack_rel), 16'(D + W + TO));
      chk("to_dout", ack_dout, 16'hFFFF);
      release_bus();

      start_access(2'b01, 16'h0000, 1'b1, 1'b1, 1'b0);
      repeat (10) tick();
      cs = 1'b0;
      repeat (40) tick();
      chk("abort_irq", 16'(irq_low), 16'd0);
      chk("abort_ack", 16'(acks), 16'd0);
      release_bus();
      read_access(2'b10, 8'h5A, 16'h5A5A, 1'b0);

      start_access(2'b01, 16'h0000, 1'b1, 1'b1, 1'b0);
      wait_irq();
      repeat (6) tick();
      resetn = 1'b0;
      #1;
      chk("arst_irqn", 16'(slave_irqn), 16'd1);
      chk("arst_ack", 16'(cpu_bus_ack), 16'd0);
      chk("arst_dout", cpu_dout, 16'h0000);
      chk("arst_rw_n", 16'(slave_rw_n), 16'd1);
      cs = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0;
      tick(); tick();
      resetn = 1'b1;
      slave_dtackn = 1'b1;
      repeat (3) tick();
      chk("arst_no_ack", 16'(acks), 16'd0);

      slave_in2n = 1'b0;
      chk("int2_before", 16'(cpu_int2), 16'd0);
      tick();
      chk("int2_after", 16'(cpu_int2), 16'd1);
      slave_in2n = 1'b1;
      tick();
      chk("int2_clear", 16'(cpu_int2), 16'd0);
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
